// File: rtl/reset_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reset_seq_pkg                                              |
// | Description : Shared types and constants for the staged reset sequencer: |
// |               FSM state encoding, request source indices, and the value  |
// |               the stage reset outputs take while a sequence is held.     |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

  // Request source indices into req_i / req_mask_i
  localparam int SRC_WB  = 0;
  localparam int SRC_TTC = 1;
  localparam int SRC_SCA = 2;

  // Per-bit value of stage_reset_o while all stages are held
  localparam logic STAGE_RESET_VAL = 1'b1;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reset_seq_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reset_seq_timer                                            |
// | Description : Loadable down-counter shared by the delay, hold and settle |
// |               intervals. Loading value N-1 makes zero assert N cycles    |
// |               later; the count parks at zero until reloaded.             |
// | Ports       : clk   - clock                                              |
// |               load  - load value into the counter this edge              |
// |               value - load value                                         |
// |               zero  - counter currently at zero                          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module reset_seq_timer
  import reset_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // No reset of its own: the owner asserts load during its reset.
  always_ff @(posedge clk) begin
    if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reset_sequencer                                            |
// | Description : Arbitrated, staged reset controller. Merges reset requests |
// |               from several sources into one sequence, holds all stages   |
// |               in reset, then releases them in index order with a settle  |
// |               gap between stages.                                        |
// | Build macro : RESET_SEQUENCER_WB_DELAY_EN - when defined, a grant that   |
// |               contains source 0 waits DELAY_CNT cycles before asserting  |
// |               the stages (lets the wishbone response complete).          |
// | Ports       : clock_i       - fabric clock                               |
// |               reset_i       - synchronous active-high reset              |
// |               req_i         - per-source reset request                   |
// |               req_mask_i    - 1 = ignore that source                     |
// |               stage_reset_o - per-stage active-high reset (registered)   |
// |               busy_o        - sequence in progress                       |
// |               done_o        - one-cycle pulse after the last release     |
// |               last_src_o    - lowest source index of most recent grant   |
// |               req_count_o   - grant count, saturating at 255             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int NSTAGES    = 4,
  parameter int DELAY_CNT  = 1023,
  parameter int HOLD_CNT   = 255,
  parameter int SETTLE_CNT = 15
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ-1:0]         req_mask_i,
  output logic [NSTAGES-1:0]      stage_reset_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [$clog2(NREQ)-1:0] last_src_o,
  output logic [7:0]              req_count_o
);

  localparam int SRC_W = $clog2(NREQ);
  localparam int STG_W = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

`ifdef RESET_SEQUENCER_WB_DELAY_EN
  localparam bit DELAY_EN = 1'b1;
`else
  localparam bit DELAY_EN = 1'b0;
`endif

  // The delay interval only sizes the counter when the delay state exists
  localparam int DELAY_SIZE = DELAY_EN ? DELAY_CNT : 0;
  localparam int CNT_MAX    = max_of(DELAY_SIZE, max_of(HOLD_CNT, SETTLE_CNT));
  localparam int CNT_W      = $clog2(CNT_MAX) + 1;

  localparam logic [NSTAGES-1:0] STAGES_ON = {NSTAGES{STAGE_RESET_VAL}};

  seq_state_t        state, state_n;
  logic [NREQ-1:0]   pending, pending_n;
  logic [NREQ-1:0]   active, req_set;
  logic [STG_W-1:0]  stage_idx, stage_idx_n;
  logic [NSTAGES-1:0] stage_n;
  logic              busy_n, done_n;
  logic [SRC_W-1:0]  last_src_n, low_src;
  logic [7:0]        count_n;
  logic              tmr_load, tmr_zero;
  logic [CNT_W-1:0]  tmr_value;

  assign active  = req_i & ~req_mask_i;
  assign req_set = pending | active;

  // Lowest set index of the request set (scan high to low, last hit wins)
  always_comb begin
    low_src = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_set[i]) low_src = SRC_W'(i);
    end
  end

  reset_seq_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk   (clock_i),
    .load  (tmr_load),
    .value (tmr_value),
    .zero  (tmr_zero)
  );

  // Timer is loaded with N-1 so zero is seen on the Nth edge after loading.
  always_comb begin
    state_n     = state;
    stage_n     = stage_reset_o;
    stage_idx_n = stage_idx;
    pending_n   = req_set;
    last_src_n  = last_src_o;
    count_n     = req_count_o;
    done_n      = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = '0;

    case (state)
      ST_IDLE: begin
        if (req_set != '0) begin
          pending_n  = '0;
          last_src_n = low_src;
          if (req_count_o != 8'hFF) count_n = req_count_o + 8'd1;
          state_n    = ST_ASSERT;
          stage_n    = STAGES_ON;
          tmr_load   = 1'b1;
          tmr_value  = CNT_W'(HOLD_CNT - 1);
`ifdef RESET_SEQUENCER_WB_DELAY_EN
          if ((DELAY_CNT > 0) && req_set[SRC_WB]) begin
            state_n   = ST_DELAY;
            stage_n   = '0;
            tmr_value = CNT_W'(DELAY_CNT - 1);
          end
`endif
        end
      end

`ifdef RESET_SEQUENCER_WB_DELAY_EN
      ST_DELAY: begin
        stage_n = '0;
        if (tmr_zero) begin
          state_n   = ST_ASSERT;
          stage_n   = STAGES_ON;
          tmr_load  = 1'b1;
          tmr_value = CNT_W'(HOLD_CNT - 1);
        end
      end
`endif

      ST_ASSERT: begin
        stage_n = STAGES_ON;
        if (tmr_zero) begin
          stage_n[0] = 1'b0;
          if (NSTAGES == 1) begin
            state_n = ST_DONE;
          end else begin
            state_n     = ST_RELEASE;
            stage_idx_n = STG_W'(1);
            tmr_load    = 1'b1;
            tmr_value   = CNT_W'(SETTLE_CNT - 1);
          end
        end
      end

      ST_RELEASE: begin
        if (tmr_zero) begin
          stage_n[stage_idx] = 1'b0;
          if (stage_idx == STG_W'(NSTAGES - 1)) begin
            state_n = ST_DONE;
          end else begin
            stage_idx_n = stage_idx + STG_W'(1);
            tmr_load    = 1'b1;
            tmr_value   = CNT_W'(SETTLE_CNT - 1);
          end
        end
      end

      // done_o is registered, so it becomes visible on the edge leaving DONE,
      // the same edge on which busy_o falls.
      ST_DONE: begin
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end

      default: begin
        state_n = ST_IDLE;
        stage_n = '0;
      end
    endcase

    busy_n = (state_n != ST_IDLE);

    // Reset restarts the hold interval regardless of the current state
    if (reset_i) begin
      tmr_load  = 1'b1;
      tmr_value = CNT_W'(HOLD_CNT - 1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state         <= ST_ASSERT;
      stage_reset_o <= STAGES_ON;
      stage_idx     <= '0;
      busy_o        <= 1'b1;
      done_o        <= 1'b0;
      pending       <= '0;
      last_src_o    <= '0;
      req_count_o   <= '0;
    end else begin
      state         <= state_n;
      stage_reset_o <= stage_n;
      stage_idx     <= stage_idx_n;
      busy_o        <= busy_n;
      done_o        <= done_n;
      pending       <= pending_n;
      last_src_o    <= last_src_n;
      req_count_o   <= count_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reset_sequencer                                         |
// | Description : Self-checking bench for reset_sequencer: vector table for  |
// |               a full undelayed sequence and masking, plus hand-written   |
// |               power-on, back-to-back, delay and mid-sequence reset runs. |
// | Build macro : RESET_SEQUENCER_WB_DELAY_EN selects the delayed-grant      |
// |               expectations for source 0.                                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_reset_sequencer;

  logic       clk;
  logic       reset_i;
  logic [2:0] req_i;
  logic [2:0] req_mask_i;
  logic [3:0] stage_reset_o;
  logic       busy_o;
  logic       done_o;
  logic [1:0] last_src_o;
  logic [7:0] req_count_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  reset_sequencer #(
    .NREQ       (3),
    .NSTAGES    (4),
    .DELAY_CNT  (1023),
    .HOLD_CNT   (255),
    .SETTLE_CNT (15)
  ) dut (
    .clock_i       (clk),
    .reset_i       (reset_i),
    .req_i         (req_i),
    .req_mask_i    (req_mask_i),
    .stage_reset_o (stage_reset_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .last_src_o    (last_src_o),
    .req_count_o   (req_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] req;
    logic [2:0] mask;
    int         n;
    logic [3:0] stage;
    logic       busy;
    logic       done;
    logic [1:0] src;
    logic [7:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] req, input logic [2:0] mask,
                              input int n, input logic [3:0] stage,
                              input logic busy, input logic done,
                              input logic [1:0] src, input logic [7:0] cnt);
    vec_t v;
    v.req = req; v.mask = mask; v.n = n; v.stage = stage;
    v.busy = busy; v.done = done; v.src = src; v.cnt = cnt;
    return v;
  endfunction

  // Advance one edge; return just after it so outputs are settled
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  vec_t vec [12];
  int   r_edge;
  int   t0;
  int   fall [4];
  int   done_edge;
  int   done_pulses;

  initial begin
    reset_i    = 1'b1;
    req_i      = '0;
    req_mask_i = '0;

    // ---------------- power-on reset ----------------
    repeat (5) tick();
    r_edge  = cyc;
    reset_i = 1'b0;
    chk("por_stage", 32'(stage_reset_o), 32'hF);
    chk("por_busy",  32'(busy_o),        32'd1);
    chk("por_done",  32'(done_o),        32'd0);
    chk("por_src",   32'(last_src_o),    32'd0);
    chk("por_count", 32'(req_count_o),   32'd0);

    for (int k = 0; k < 4; k++) fall[k] = -1;
    done_edge   = -1;
    done_pulses = 0;
    for (int i = 1; i <= 310; i++) begin
      tick();
      for (int k = 0; k < 4; k++)
        if (fall[k] < 0 && stage_reset_o[k] == 1'b0) fall[k] = cyc - r_edge;
      if (done_o) begin
        done_pulses++;
        done_edge = cyc - r_edge;
      end
    end
    chk("por_stage0_fall", 32'(fall[0]),     32'd255);
    chk("por_stage1_fall", 32'(fall[1]),     32'd270);
    chk("por_stage3_fall", 32'(fall[3]),     32'd300);
    chk("por_done_edge",   32'(done_edge),   32'd301);
    chk("por_done_pulses", 32'(done_pulses), 32'd1);
    chk("por_idle_busy",   32'(busy_o),      32'd0);

    // ---------------- table: undelayed grant of 3'b110, then masking ----------------
    // n = edges advanced; req/mask are applied for the first of those edges.
    vec[0]  = mk(3'b110, 3'b000,   1, 4'hF, 1'b1, 1'b0, 2'd1, 8'd1); // edge 0 grant
    vec[1]  = mk(3'b000, 3'b000, 254, 4'hF, 1'b1, 1'b0, 2'd1, 8'd1); // edge 254
    vec[2]  = mk(3'b000, 3'b000,   1, 4'hE, 1'b1, 1'b0, 2'd1, 8'd1); // edge 255
    vec[3]  = mk(3'b000, 3'b000,  14, 4'hE, 1'b1, 1'b0, 2'd1, 8'd1); // edge 269
    vec[4]  = mk(3'b000, 3'b000,   1, 4'hC, 1'b1, 1'b0, 2'd1, 8'd1); // edge 270
    vec[5]  = mk(3'b000, 3'b000,  15, 4'h8, 1'b1, 1'b0, 2'd1, 8'd1); // edge 285
    vec[6]  = mk(3'b000, 3'b000,  14, 4'h8, 1'b1, 1'b0, 2'd1, 8'd1); // edge 299
    vec[7]  = mk(3'b000, 3'b000,   1, 4'h0, 1'b1, 1'b0, 2'd1, 8'd1); // edge 300
    vec[8]  = mk(3'b000, 3'b000,   1, 4'h0, 1'b0, 1'b1, 2'd1, 8'd1); // edge 301 done
    vec[9]  = mk(3'b000, 3'b000,   1, 4'h0, 1'b0, 1'b0, 2'd1, 8'd1); // edge 302 idle
    vec[10] = mk(3'b111, 3'b111,   1, 4'h0, 1'b0, 1'b0, 2'd1, 8'd1); // all masked
    vec[11] = mk(3'b000, 3'b111,   5, 4'h0, 1'b0, 1'b0, 2'd1, 8'd1); // still idle

    for (int i = 0; i < 12; i++) begin
      req_i      = vec[i].req;
      req_mask_i = vec[i].mask;
      tick();
      req_i = '0;
      for (int j = 1; j < vec[i].n; j++) tick();
      chk($sformatf("vec%0d_stage", i), 32'(stage_reset_o), 32'(vec[i].stage));
      chk($sformatf("vec%0d_busy",  i), 32'(busy_o),        32'(vec[i].busy));
      chk($sformatf("vec%0d_done",  i), 32'(done_o),        32'(vec[i].done));
      chk($sformatf("vec%0d_src",   i), 32'(last_src_o),    32'(vec[i].src));
      chk($sformatf("vec%0d_count", i), 32'(req_count_o),   32'(vec[i].cnt));
    end
    req_mask_i = '0;
    tick();

    // ---------------- back-to-back: req[1] at 0, req[2] at 100 ----------------
    req_i = 3'b010;
    tick();
    req_i = '0;
    t0 = cyc;
    wait_until(t0 + 99);
    req_i = 3'b100;
    tick();
    req_i = '0;
    chk("b2b_busy_100", 32'(busy_o), 32'd1);
    wait_until(t0 + 300);
    chk("b2b_done_300", 32'(done_o), 32'd0);
    wait_until(t0 + 301);
    chk("b2b_done_301", 32'(done_o), 32'd1);
    chk("b2b_busy_301", 32'(busy_o), 32'd0);
    chk("b2b_src_301",  32'(last_src_o), 32'd1);
    wait_until(t0 + 302);
    chk("b2b_regrant_busy",  32'(busy_o),        32'd1);
    chk("b2b_regrant_stage", 32'(stage_reset_o), 32'hF);
    chk("b2b_regrant_src",   32'(last_src_o),    32'd2);
    chk("b2b_regrant_count", 32'(req_count_o),   32'd3);
    chk("b2b_regrant_done",  32'(done_o),        32'd0);
    wait_until(t0 + 603);
    chk("b2b_second_done", 32'(done_o), 32'd1);
    wait_until(t0 + 604);
    chk("b2b_no_third", 32'(busy_o), 32'd0);

    // ---------------- source 0 (wishbone) grant ----------------
    req_i = 3'b001;
    tick();
    req_i = '0;
    t0 = cyc;
    chk("wb_busy_0",  32'(busy_o),      32'd1);
    chk("wb_src_0",   32'(last_src_o),  32'd0);
    chk("wb_count_0", 32'(req_count_o), 32'd4);
`ifdef RESET_SEQUENCER_WB_DELAY_EN
    chk("wb_stage_0", 32'(stage_reset_o), 32'h0);
    wait_until(t0 + 1022);
    chk("wb_stage_1022", 32'(stage_reset_o), 32'h0);
    wait_until(t0 + 1023);
    chk("wb_stage_1023", 32'(stage_reset_o), 32'hF);
    wait_until(t0 + 1277);
    chk("wb_stage_1277", 32'(stage_reset_o), 32'hF);
    wait_until(t0 + 1278);
    chk("wb_stage_1278", 32'(stage_reset_o), 32'hE);
    wait_until(t0 + 1323);
    chk("wb_stage_1323", 32'(stage_reset_o), 32'h0);
    chk("wb_done_1323",  32'(done_o),        32'd0);
    wait_until(t0 + 1324);
    chk("wb_done_1324",  32'(done_o),        32'd1);
    chk("wb_busy_1324",  32'(busy_o),        32'd0);
`else
    chk("wb_stage_0", 32'(stage_reset_o), 32'hF);
    wait_until(t0 + 254);
    chk("wb_stage_254", 32'(stage_reset_o), 32'hF);
    wait_until(t0 + 255);
    chk("wb_stage_255", 32'(stage_reset_o), 32'hE);
    wait_until(t0 + 300);
    chk("wb_stage_300", 32'(stage_reset_o), 32'h0);
    chk("wb_done_300",  32'(done_o),        32'd0);
    wait_until(t0 + 301);
    chk("wb_done_301",  32'(done_o),        32'd1);
    chk("wb_busy_301",  32'(busy_o),        32'd0);
`endif
    tick();

    // ---------------- reset_i mid-sequence ----------------
    req_i = 3'b010;
    tick();
    req_i = '0;
    t0 = cyc;
    wait_until(t0 + 279);
    chk("mid_stage_279", 32'(stage_reset_o), 32'hC);
    chk("mid_count_279", 32'(req_count_o),   32'd5);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    r_edge = cyc;
    chk("mid_rst_stage", 32'(stage_reset_o), 32'hF);
    chk("mid_rst_count", 32'(req_count_o),   32'd0);
    chk("mid_rst_src",   32'(last_src_o),    32'd0);
    chk("mid_rst_busy",  32'(busy_o),        32'd1);
    wait_until(r_edge + 1);
    chk("mid_stage_281", 32'(stage_reset_o), 32'hF);
    wait_until(r_edge + 254);
    chk("mid_stage_r254", 32'(stage_reset_o), 32'hF);
    wait_until(r_edge + 255);
    chk("mid_stage_r255", 32'(stage_reset_o), 32'hE);
    wait_until(r_edge + 300);
    chk("mid_stage_r300", 32'(stage_reset_o), 32'h0);
    wait_until(r_edge + 301);
    chk("mid_done_r301", 32'(done_o), 32'd1);
    wait_until(r_edge + 303);
    chk("mid_idle_after", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
